dmem_dma_copy: RTL and testbench
================================

Name: dmem_dma_copy

Overview:
- Bus initiator for the 16-bit data memory/IO responder. It drives the same addr/wdata/write/read/rdata interface as the processor datapath.
- Copies a block of 16-bit words from a source byte address to a destination byte address, using one read cycle and one write cycle per word.
- Sits beside the CPU on the data-memory bus. An external arbiter muxes its bus outputs onto the memory while busy=1.
- Also serves IO: source 0xfff0 samples the switches; destination 0xfffa loads the seven-segment display.

Parameters:
- CNT_W, 8, width of the word-count input; 1..255 words per transfer.
- ADDR_STEP, 2, byte increment per word (word-aligned, big-endian memory).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level-sampled request; acted on only in IDLE.
- src_addr  in  16  source byte address; bit 0 ignored.
- dst_addr  in  16  destination byte address; bit 0 ignored.
- count  in  CNT_W  number of words to copy.
- mem_rdata  in  16  read data from the memory/IO block; combinational, valid in the same cycle as mem_addr/mem_read.
- mem_addr  out  16  bus address.
- mem_wdata  out  16  bus write data.
- mem_read  out  1  read enable.
- mem_write  out  1  write enable.
- busy  out  1  high in RD and WR states.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: one clock and one synchronous active-high reset. Reset has priority over all other inputs. On reset the state goes to IDLE and src_ptr, dst_ptr, remaining and data buffer clear to 0.
- Outputs during and after reset: mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0, busy=0, done=0. No write is issued in a reset cycle.
- Outputs are decoded from registered state and pointers only. There is no combinational path from start, src_addr, dst_addr or count to any output.
- States: IDLE, RD, WR, DONE.
- IDLE: all bus outputs are 0.
  - At an edge with start=1 and count!=0: latch src_ptr={src_addr[15:1],0}, dst_ptr={dst_addr[15:1],0}, remaining=count; go to RD.
  - At an edge with start=1 and count==0: go to DONE with no bus activity.
- RD: mem_addr=src_ptr, mem_read=1, mem_write=0.
  - At the edge: buffer<=mem_rdata, src_ptr<=src_ptr+ADDR_STEP; go to WR.
- WR: mem_addr=dst_ptr, mem_wdata=buffer, mem_write=1, mem_read=0.
  - At the edge: dst_ptr<=dst_ptr+ADDR_STEP, remaining<=remaining-1.
  - If remaining==1 go to DONE, else go to RD.
- DONE: done=1, busy=0, bus outputs 0; go to IDLE at the next edge.
- Latency: with start sampled at edge E0, an N-word copy occupies exactly 2N cycles of RD/WR. done is high in cycle 2N+1 after E0. For count=0, done is high in cycle 1.
- Pointer arithmetic is modulo 2^16; 0xfffe+2 wraps to 0x0000 with no flag.
- Overlapping ranges copy in ascending address order with no overlap protection. dst=src+2 therefore replicates the first word.
- Input sampling:
  - start is ignored in RD, WR and DONE.
  - src_addr, dst_addr and count are sampled only at the accepting edge. Later changes have no effect.
- Reset during RD or WR aborts the transfer. Words already written stay written. done is not pulsed.

Optional Feature:
- Macro DMA_FILL_EN adds input ports fill (1) and fill_value (16).
- With the macro defined: if fill=1 at the accepting edge, fill_value is latched into the buffer and the engine skips RD. It loops WR-only, writing fill_value to count words from dst_ptr in N cycles; done is high in cycle N+1. fill=0 gives normal copy.
- Without the macro: the ports do not exist and behaviour is copy-only as above.

Test Plan:
- Memory 0x0010..0x0016 = 0x1111,0x2222,0x3333,0x4444; start src=0x0010, dst=0x0080, count=4 -> 0x0080..0x0086 hold the same values. busy is high for 8 cycles; done pulses in cycle 9; mem_write is high in exactly 4 cycles.
- count=0, start=1 -> done in cycle 1; mem_read and mem_write never assert; busy stays 0.
- Switches sw1=1, sw0=0; src=0xfff0, dst=0x0020, count=1 -> memory 0x0020=0x0002.
- Memory 0x0040=0x005B; src=0x0040, dst=0xfffa, count=1 -> io_display=7'h5B.
- Reset asserted in the 3rd WR of a 6-word copy -> outputs 0 on the next cycle, no done pulse, only the first 2 destination words modified. A new start then runs normally. start pulsed while busy -> ignored.
- DMA_FILL_EN defined: fill=1, fill_value=0xA5A5, dst=0x00F8, count=3 -> 0x00F8, 0x00FA, 0x00FC = 0xA5A5; no mem_read; done in cycle 4.

Source files
------------

// File: rtl/dmem_dma_copy.sv
// dmem_dma_copy
// Bus initiator that copies a block of 16-bit words from a source byte
// address to a destination byte address over the data-memory/IO bus. Each
// word takes one read cycle followed by one write cycle. The IO responder
// on the same bus also makes the switches (0xfff0) and the display (0xfffa)
// reachable as ordinary source/destination addresses.
//
// Optional feature: define DMA_FILL_EN to add the fill/fill_value ports.
// When fill is high at the accepting edge, fill_value is written to every
// destination word and no reads are issued.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   transfer request, only acted on while idle
//   src_addr    in   source byte address (bit 0 ignored)
//   dst_addr    in   destination byte address (bit 0 ignored)
//   count       in   number of words to copy (0 completes immediately)
//   fill        in   (DMA_FILL_EN only) select fill instead of copy
//   fill_value  in   (DMA_FILL_EN only) word written in fill mode
//   mem_rdata   in   combinational read data from memory/IO
//   mem_addr    out  bus address
//   mem_wdata   out  bus write data
//   mem_read    out  read enable
//   mem_write   out  write enable
//   busy        out  high while reading or writing
//   done        out  single-cycle completion pulse
module dmem_dma_copy #(
  parameter int CNT_W     = 8,
  parameter int ADDR_STEP = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      src_addr,
  input  logic [15:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
`ifdef DMA_FILL_EN
  input  logic             fill,
  input  logic [15:0]      fill_value,
`endif
  input  logic [15:0]      mem_rdata,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  localparam logic [15:0] STEP = 16'(ADDR_STEP);

  state_t           state_q, state_d;
  logic [15:0]      srcPtr_q, srcPtr_d;
  logic [15:0]      dstPtr_q, dstPtr_d;
  logic [15:0]      buffer_q, buffer_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             fillMode_q, fillMode_d;

  logic             fillReq;
  logic [15:0]      fillValue;

`ifdef DMA_FILL_EN
  assign fillReq   = fill;
  assign fillValue = fill_value;
`else
  assign fillReq   = 1'b0;
  assign fillValue = 16'h0000;
`endif

  // State and datapath registers; reset returns everything to an idle,
  // empty engine so an aborted transfer leaves no trace.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      srcPtr_q    <= 16'h0000;
      dstPtr_q    <= 16'h0000;
      buffer_q    <= 16'h0000;
      remaining_q <= '0;
      fillMode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      srcPtr_q    <= srcPtr_d;
      dstPtr_q    <= dstPtr_d;
      buffer_q    <= buffer_d;
      remaining_q <= remaining_d;
      fillMode_q  <= fillMode_d;
    end
  end

  // Next-state logic. Request inputs are only looked at in IDLE, so later
  // changes to them cannot disturb a transfer in flight. Addresses are
  // forced word-aligned at acceptance; pointer adds wrap modulo 2^16.
  always_comb begin
    state_d     = state_q;
    srcPtr_d    = srcPtr_q;
    dstPtr_d    = dstPtr_q;
    buffer_d    = buffer_q;
    remaining_d = remaining_q;
    fillMode_d  = fillMode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_d = DONE;
          end else begin
            srcPtr_d    = src_addr & 16'hFFFE;
            dstPtr_d    = dst_addr & 16'hFFFE;
            remaining_d = count;
            fillMode_d  = fillReq;
            if (fillReq) begin
              buffer_d = fillValue;
              state_d  = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        buffer_d = mem_rdata;
        srcPtr_d = srcPtr_q + STEP;
        state_d  = WR;
      end
      WR: begin
        dstPtr_d    = dstPtr_q + STEP;
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = DONE;
        end else if (fillMode_q) begin
          state_d = WR;
        end else begin
          state_d = RD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs come from registered state only. They are forced to zero
  // while reset is high so an abort in WR cannot complete that write.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    if (!reset) begin
      case (state_q)
        RD: begin
          mem_addr = srcPtr_q;
          mem_read = 1'b1;
          busy     = 1'b1;
        end
        WR: begin
          mem_addr  = dstPtr_q;
          mem_wdata = buffer_q;
          mem_write = 1'b1;
          busy      = 1'b1;
        end
        DONE: begin
          done = 1'b1;
        end
        default: begin
          mem_addr = 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dma_copy.sv
// tb_dmem_dma_copy
// Self-checking bench for dmem_dma_copy. A behavioural memory/IO responder
// (word array, switches at 0xfff0, display at 0xfffa) sits on the bus.
// Each request queues the bus events the copy must produce, each tagged
// with its cycle. A monitor on the falling edge pops and compares them, then
// commits the expected writes into a reference memory image.
// Define DMA_FILL_EN to also exercise the fill ports.
module tb_dmem_dma_copy;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] srcAddr;
  logic [15:0] dstAddr;
  logic [7:0]  count;
  logic [15:0] memRdata;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        memRead;
  logic        memWrite;
  logic        busy;
  logic        done;
`ifdef DMA_FILL_EN
  logic        fill;
  logic [15:0] fillValue;
`endif

  logic [1:0]  sw;
  logic [6:0]  ioDisplay   = 7'h00;
  logic [6:0]  expDisplay  = 7'h00;
  logic [15:0] dmem   [0:32767];
  logic [15:0] refmem [0:32767];

  int cyc     = 0;
  int total   = 0;
  int bad     = 0;
  int busyCnt = 0;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t sbq[$];

  dmem_dma_copy #(.CNT_W(8), .ADDR_STEP(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .src_addr  (srcAddr),
    .dst_addr  (dstAddr),
    .count     (count),
`ifdef DMA_FILL_EN
    .fill      (fill),
    .fill_value(fillValue),
`endif
    .mem_rdata (memRdata),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_read  (memRead),
    .mem_write (memWrite),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Cycle number; cycle k is the period that follows the k-th rising edge.
  always @(posedge clock) cyc = cyc + 1;

  // Memory/IO responder: combinational read, write on the rising edge.
  assign memRdata = (memAddr == 16'hfff0) ? {14'd0, sw} : dmem[memAddr[15:1]];

  always @(posedge clock) begin
    if (memWrite) begin
      if (memAddr == 16'hfffa) ioDisplay = memWdata[6:0];
      else dmem[memAddr[15:1]] = memWdata;
    end
  end

  // Scoreboard monitor: every cycle with bus activity must match the head
  // of the queue in cycle, kind, address and data.
  always @(negedge clock) begin
    ev_t        e;
    logic [2:0] got;
    logic [2:0] expBits;
    bit         ok;
    if (!reset) begin
      if (busy) busyCnt++;
      got = {memRead, memWrite, done};
      if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        total++;
        case (e.kind)
          0:       expBits = 3'b100;
          1:       expBits = 3'b010;
          default: expBits = 3'b001;
        endcase
        ok = (e.cyc == cyc) && (got == expBits) && (memAddr == e.addr) &&
             (e.kind != 1 || memWdata == e.data);
        if (!ok) begin
          bad++;
          $display("[TB] FAIL busev cyc=%0d got rd/wr/dn=%b addr=%h wdata=%h, required cyc=%0d rd/wr/dn=%b addr=%h wdata=%h",
                   cyc, got, memAddr, memWdata, e.cyc, expBits, e.addr, e.data);
        end
        if (e.kind == 1) begin
          if (e.addr == 16'hfffa) expDisplay = e.data[6:0];
          else refmem[e.addr[15:1]] = e.data;
        end
      end else if (got != 3'b000) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected cyc=%0d rd/wr/dn=%b addr=%h, required no activity",
                 cyc, got, memAddr);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput(name, {28'd0, memAddr, memWdata, memRead, memWrite, busy, done}, 64'd0);
  endtask

  task automatic setWord(input logic [15:0] a, input logic [15:0] v);
    dmem[a[15:1]]   = v;
    refmem[a[15:1]] = v;
  endtask

  function automatic void pushEv(input int c, input int k, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sbq.push_back(e);
  endfunction

  // Issues one request (called just after a rising edge with the engine
  // idle) and queues the spec-level outcome: word i is read in cycle 2i+1
  // and written in 2i+2 (fill: written in i+1), done one cycle after the
  // last write. Reads see earlier writes of the same transfer, which is
  // what makes overlapping copies replicate data.
  task automatic applyStimulus(input logic [15:0] src, input logic [15:0] dst, input int n,
                               input bit fl, input logic [15:0] fv, output int c);
    logic [15:0] s;
    logic [15:0] d;
    logic [15:0] v;
    logic [15:0] pend [int];
    c = cyc;
    s = src & 16'hfffe;
    d = dst & 16'hfffe;
    for (int i = 0; i < n; i++) begin
      if (fl) begin
        v = fv;
        pushEv(c + 1 + i, 1, d, v);
      end else begin
        if (s == 16'hfff0) v = {14'd0, sw};
        else if (pend.exists(int'(s))) v = pend[int'(s)];
        else v = refmem[s[15:1]];
        pushEv(c + 1 + 2 * i, 0, s, 16'h0000);
        pushEv(c + 2 + 2 * i, 1, d, v);
      end
      if (d != 16'hfffa) pend[int'(d)] = v;
      s = s + 16'd2;
      d = d + 16'd2;
    end
    pushEv(c + (fl ? n : 2 * n) + 1, 2, 16'h0000, 16'h0000);
    srcAddr = src;
    dstAddr = dst;
    count   = 8'(n);
`ifdef DMA_FILL_EN
    fill      = fl;
    fillValue = fv;
`endif
    start   = 1'b1;
    busyCnt = 0;
    @(posedge clock); #1;
    start   = 1'b0;
    srcAddr = 16'($urandom);
    dstAddr = 16'($urandom);
    count   = 8'($urandom);
`ifdef DMA_FILL_EN
    fill      = 1'($urandom);
    fillValue = 16'($urandom);
`endif
  endtask

  // Waits for the queued events to drain, optionally pulsing start while the
  // engine is busy, then checks the number of busy cycles.
  task automatic waitDone(input int c, input int n, input bit fl, input bit poke);
    int budget = 2 * n + 8;
    int k = 0;
    while (sbq.size() != 0 && k < budget) begin
      if (poke && cyc == c + 3) begin
        start = 1'b1;
        count = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      k++;
    end
    start = 1'b0;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout pending=%0d required=0", sbq.size());
      sbq.delete();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
    end else begin
      checkOutput("busycycles", 64'(busyCnt), 64'(fl ? n : 2 * n));
    end
  endtask

  initial begin
    int          c;
    int          n;
    int          diffs;
    logic [15:0] v;
    logic [15:0] orig3;
    reset   = 1'b1;
    start   = 1'b0;
    srcAddr = 16'h0000;
    dstAddr = 16'h0000;
    count   = 8'd0;
    sw      = 2'b00;
`ifdef DMA_FILL_EN
    fill      = 1'b0;
    fillValue = 16'h0000;
`endif
    for (int i = 0; i < 32768; i++) begin
      v = 16'($urandom);
      dmem[i]   = v;
      refmem[i] = v;
    end
    @(posedge clock); #1;
    checkIdle("inreset");
    @(posedge clock); #1;
    reset = 1'b0;
    checkIdle("afterreset");

    // Four-word copy 0x0010 -> 0x0080.
    setWord(16'h0010, 16'h1111);
    setWord(16'h0012, 16'h2222);
    setWord(16'h0014, 16'h3333);
    setWord(16'h0016, 16'h4444);
    applyStimulus(16'h0010, 16'h0080, 4, 1'b0, 16'h0000, c);
    waitDone(c, 4, 1'b0, 1'b0);
    checkOutput("copy4last", dmem[16'h0086 >> 1], 16'h4444);

    // Zero count: done in cycle 1, no bus activity.
    applyStimulus(16'h0200, 16'h0300, 0, 1'b0, 16'h0000, c);
    waitDone(c, 0, 1'b0, 1'b0);

    // Switches to memory.
    sw = 2'b10;
    applyStimulus(16'hfff0, 16'h0020, 1, 1'b0, 16'h0000, c);
    waitDone(c, 1, 1'b0, 1'b0);
    checkOutput("swcopy", dmem[16'h0020 >> 1], 16'h0002);

    // Memory to display.
    setWord(16'h0040, 16'h005B);
    applyStimulus(16'h0040, 16'hfffa, 1, 1'b0, 16'h0000, c);
    waitDone(c, 1, 1'b0, 1'b0);
    checkOutput("display", ioDisplay, 7'h5B);

    // Reset during the third write of a six-word copy.
    orig3 = refmem[16'h0504 >> 1];
    applyStimulus(16'h0401, 16'h0500, 6, 1'b0, 16'h0000, c);
    repeat (5) begin
      @(posedge clock); #1;
    end
    sbq.delete();
    reset = 1'b1;
    #1;
    checkIdle("abortcycle");
    @(posedge clock); #1;
    reset = 1'b0;
    checkIdle("abortnext");
    repeat (4) begin
      @(posedge clock); #1;
    end
    checkOutput("abortword3", dmem[16'h0504 >> 1], orig3);
    checkOutput("abortword1", dmem[16'h0500 >> 1], dmem[16'h0400 >> 1]);

    // Wrap-around, overlapping copy, start pulsed while busy.
    applyStimulus(16'h0600, 16'hfffc, 3, 1'b0, 16'h0000, c);
    waitDone(c, 3, 1'b0, 1'b0);
    applyStimulus(16'h0700, 16'h0702, 4, 1'b0, 16'h0000, c);
    waitDone(c, 4, 1'b0, 1'b1);
    checkOutput("overlap", dmem[16'h0708 >> 1], dmem[16'h0700 >> 1]);
    applyStimulus(16'h0800, 16'h0900, 5, 1'b0, 16'h0000, c);
    waitDone(c, 5, 1'b0, 1'b1);

`ifdef DMA_FILL_EN
    applyStimulus(16'h0000, 16'h00F8, 3, 1'b1, 16'hA5A5, c);
    waitDone(c, 3, 1'b1, 1'b0);
    checkOutput("fillword", dmem[16'h00FC >> 1], 16'hA5A5);
`endif

    // Randomized transfers in a shared window so ranges often overlap.
    for (int t = 0; t < 12; t++) begin
      bit fl;
      n  = $urandom_range(0, 20);
      sw = 2'($urandom);
`ifdef DMA_FILL_EN
      fl = 1'($urandom);
`else
      fl = 1'b0;
`endif
      applyStimulus(16'h0100 + 16'($urandom_range(0, 255)), 16'h0100 + 16'($urandom_range(0, 255)),
                    n, fl, 16'($urandom), c);
      waitDone(c, n, fl, (n >= 1) && ($urandom_range(0, 1) == 1));
    end

    diffs = 0;
    for (int i = 0; i < 32768; i++) begin
      if (dmem[i] !== refmem[i]) diffs++;
    end
    checkOutput("memimage", 64'(diffs), 64'd0);
    checkOutput("displayfinal", ioDisplay, expDisplay);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
